// File: rtl/afe_sequence_controller_if.sv
// Bus between the AFE sequence controller, its synchronous command ROM and
// the AFE serial engine.
//   rom_address       : controller -> ROM, word address
//   rom_data          : ROM -> controller, {opcode[3:0], payload[CMD_WIDTH-1:0]}
//   serial_ready      : serial engine -> controller, idle/ready level
//   afe_command       : controller -> serial engine, payload of the last SEND
//   start_transaction : controller -> serial engine, one-cycle start pulse
interface afe_sequence_controller_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned CMD_WIDTH  = 20
);
    logic [ADDR_WIDTH-1:0] rom_address;
    logic [CMD_WIDTH+3:0]  rom_data;
    logic                  serial_ready;
    logic [CMD_WIDTH-1:0]  afe_command;
    logic                  start_transaction;

    // Controller side
    modport master (
        output rom_address,
        input  rom_data,
        input  serial_ready,
        output afe_command,
        output start_transaction
    );

    // ROM / serial engine side
    modport slave (
        input  rom_address,
        output rom_data,
        output serial_ready,
        input  afe_command,
        input  start_transaction
    );
endinterface

// File: rtl/afe_sequence_controller.sv
// ROM-driven AFE command sequencer. Fetches {opcode, payload} words from a
// synchronous command ROM and issues SEND transactions to the AFE serial
// engine; supports DELAY, JUMP and DONE opcodes, a serial-ready timeout, an
// address-overflow guard and a synchronous restart.
// Ports:
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   enable     : start the sequence, sampled only in IDLE
//   restart    : synchronous abort/rearm, highest non-reset priority
//   bus        : ROM / serial engine bus (master side)
//   busy       : decoded from state, high outside IDLE/DONE
//   done       : registered level, high in DONE
//   error_code : 00 none, 01 invalid opcode, 10 ready timeout, 11 addr overflow
module afe_sequence_controller #(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned CMD_WIDTH     = 20,
    parameter int unsigned DELAY_WIDTH   = 16,
    parameter int unsigned READY_TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      restart,
    afe_sequence_controller_if.master bus,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                error_code
);

    localparam int unsigned OP_W     = 4;
    localparam int unsigned TMO_W    = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;
    localparam int unsigned TMO_LAST = (READY_TIMEOUT > 0) ? READY_TIMEOUT - 1 : 0;
    localparam bit          TMO_EN   = (READY_TIMEOUT != 0);

    localparam logic [TMO_W-1:0] TMO_LAST_V = TMO_W'(TMO_LAST);

    localparam logic [OP_W-1:0] OP_DONE  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SEND  = 4'b0001;
    localparam logic [OP_W-1:0] OP_DELAY = 4'b0010;
    localparam logic [OP_W-1:0] OP_JUMP  = 4'b0011;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_INVALID  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_READY = 3'd1,
        ST_FETCH      = 3'd2,
        ST_DECODE     = 3'd3,
        ST_WAIT_BUSY  = 3'd4,
        ST_DELAY      = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    state_t state_q;
    state_t state_next;

    logic [ADDR_WIDTH-1:0]  rom_address_q, rom_address_d;
    logic [CMD_WIDTH-1:0]   afe_command_q, afe_command_d;
    logic                   start_q, start_d;
    logic                   done_q, done_d;
    logic [1:0]             error_q, error_d;
    logic [DELAY_WIDTH-1:0] delay_cnt_q, delay_cnt_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;

    logic [OP_W-1:0]        opcode;
    logic [CMD_WIDTH-1:0]   payload;
    logic [DELAY_WIDTH-1:0] delay_n;
    logic [ADDR_WIDTH-1:0]  jump_target;
    logic                   addr_last;
    logic                   tmo_expired;
    logic                   in_wait;

    // ROM word fields and shared decode terms
    assign opcode      = bus.rom_data[CMD_WIDTH+OP_W-1:CMD_WIDTH];
    assign payload     = bus.rom_data[CMD_WIDTH-1:0];
    assign delay_n     = payload[DELAY_WIDTH-1:0];
    assign jump_target = payload[ADDR_WIDTH-1:0];
    assign addr_last   = (rom_address_q == '1);
    assign tmo_expired = TMO_EN && (tmo_cnt_q == TMO_LAST_V);
    assign in_wait     = (state_q == ST_WAIT_READY) || (state_q == ST_WAIT_BUSY);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_WAIT_READY;
                end
            end
            ST_WAIT_READY: begin
                if (bus.serial_ready) begin
                    state_next = ST_FETCH;
                end else if (tmo_expired) begin
                    state_next = ST_DONE;
                end
            end
            ST_FETCH: begin
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_DONE:  state_next = ST_DONE;
                    OP_SEND:  state_next = addr_last ? ST_DONE : ST_WAIT_BUSY;
                    OP_DELAY: begin
                        if (addr_last) begin
                            state_next = ST_DONE;
                        end else if (delay_n == '0) begin
                            state_next = ST_WAIT_READY;
                        end else begin
                            state_next = ST_DELAY;
                        end
                    end
                    OP_JUMP:  state_next = ST_WAIT_READY;
                    default:  state_next = ST_DONE;
                endcase
            end
            ST_WAIT_BUSY: begin
                // Ready must fall to acknowledge the start, so a stale ready
                // level cannot launch the next fetch.
                if (!bus.serial_ready) begin
                    state_next = ST_WAIT_READY;
                end else if (tmo_expired) begin
                    state_next = ST_DONE;
                end
            end
            ST_DELAY: begin
                if (delay_cnt_q <= DELAY_WIDTH'(1)) begin
                    state_next = ST_WAIT_READY;
                end
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (restart) begin
            state_next = ST_IDLE;
        end
    end

    // Output / datapath next values
    always_comb begin
        rom_address_d = rom_address_q;
        afe_command_d = afe_command_q;
        start_d       = 1'b0;
        error_d       = error_q;
        delay_cnt_d   = delay_cnt_q;
        // Counts consecutive cycles spent in one wait state; any transition clears it
        tmo_cnt_d     = (in_wait && (state_next == state_q)) ? tmo_cnt_q + TMO_W'(1) : '0;
        done_d        = (state_next == ST_DONE);

        case (state_q)
            ST_WAIT_READY: begin
                if (!bus.serial_ready && tmo_expired) begin
                    error_d = ERR_TIMEOUT;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_DONE: begin
                        error_d = ERR_NONE;
                    end
                    OP_SEND: begin
                        if (addr_last) begin
                            error_d = ERR_OVERFLOW;
                        end else begin
                            afe_command_d = payload;
                            start_d       = 1'b1;
                            rom_address_d = rom_address_q + ADDR_WIDTH'(1);
                        end
                    end
                    OP_DELAY: begin
                        if (addr_last) begin
                            error_d = ERR_OVERFLOW;
                        end else begin
                            delay_cnt_d   = delay_n;
                            rom_address_d = rom_address_q + ADDR_WIDTH'(1);
                        end
                    end
                    OP_JUMP: begin
                        rom_address_d = jump_target;
                    end
                    default: begin
                        error_d = ERR_INVALID;
                    end
                endcase
            end
            ST_WAIT_BUSY: begin
                if (bus.serial_ready && tmo_expired) begin
                    error_d = ERR_TIMEOUT;
                end
            end
            ST_DELAY: begin
                delay_cnt_d = delay_cnt_q - DELAY_WIDTH'(1);
            end
            default: begin
            end
        endcase

        // Abort/rearm; the last command word is deliberately kept
        if (restart) begin
            rom_address_d = '0;
            start_d       = 1'b0;
            done_d        = 1'b0;
            error_d       = ERR_NONE;
            delay_cnt_d   = '0;
            tmo_cnt_d     = '0;
        end
    end

    // Output and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_address_q <= '0;
            afe_command_q <= '0;
            start_q       <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= ERR_NONE;
            delay_cnt_q   <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            rom_address_q <= rom_address_d;
            afe_command_q <= afe_command_d;
            start_q       <= start_d;
            done_q        <= done_d;
            error_q       <= error_d;
            delay_cnt_q   <= delay_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign bus.rom_address       = rom_address_q;
    assign bus.afe_command       = afe_command_q;
    assign bus.start_transaction = start_q;
    assign done                  = done_q;
    assign error_code            = error_q;
    assign busy                  = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_afe_sequence_controller.sv
// Directed bench for afe_sequence_controller: one instance with an 8-bit ROM
// address and a 16-cycle ready timeout, and one with a 2-bit address for the
// overflow guard. Synchronous ROMs and a simple serial-engine model are built
// in; expected values are hand-derived cycle counts and constants.
`timescale 1ns/1ps
module tb_afe_sequence_controller;

    localparam int unsigned AW_A = 8;
    localparam int unsigned AW_B = 2;
    localparam int unsigned CW   = 20;
    localparam int unsigned DW   = 16;
    localparam int unsigned RT   = 16;
    localparam int unsigned RW   = CW + 4;

    logic clk = 1'b0;
    logic reset_n;
    logic enable_a;
    logic enable_b;
    logic restart;
    logic busy_a, done_a, busy_b, done_b;
    logic [1:0] err_a, err_b;

    afe_sequence_controller_if #(.ADDR_WIDTH(AW_A), .CMD_WIDTH(CW)) ifa ();
    afe_sequence_controller_if #(.ADDR_WIDTH(AW_B), .CMD_WIDTH(CW)) ifb ();

    afe_sequence_controller #(
        .ADDR_WIDTH(AW_A), .CMD_WIDTH(CW), .DELAY_WIDTH(DW), .READY_TIMEOUT(RT)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable_a), .restart(restart),
        .bus(ifa), .busy(busy_a), .done(done_a), .error_code(err_a)
    );

    afe_sequence_controller #(
        .ADDR_WIDTH(AW_B), .CMD_WIDTH(CW), .DELAY_WIDTH(DW), .READY_TIMEOUT(RT)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable_b), .restart(restart),
        .bus(ifb), .busy(busy_b), .done(done_b), .error_code(err_b)
    );

    always #5 clk = ~clk;

    // Synchronous command ROMs
    logic [RW-1:0] rom_a [0:255];
    logic [RW-1:0] rom_b [0:3];
    always @(posedge clk) ifa.rom_data <= rom_a[ifa.rom_address];
    always @(posedge clk) ifb.rom_data <= rom_b[ifb.rom_address];

    // Serial model: ready drops one cycle after start, returns 10 cycles later
    int   ser_mode;   // 0 model, 1 held high, 2 held low
    logic model_ready;
    int   hold_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_ready <= 1'b1;
            hold_cnt    <= 0;
        end else if (ifa.start_transaction) begin
            model_ready <= 1'b0;
            hold_cnt    <= 10;
        end else if (hold_cnt > 0) begin
            if (hold_cnt == 1) model_ready <= 1'b1;
            hold_cnt <= hold_cnt - 1;
        end
    end
    assign ifa.serial_ready = (ser_mode == 1) ? 1'b1 : (ser_mode == 2) ? 1'b0 : model_ready;
    assign ifb.serial_ready = 1'b1;

    // Monitors: start pulses, logged commands, address wrap-backs 1 -> 0
    int            pulses_a = 0;
    int            pulses_b = 0;
    int            jumps_a  = 0;
    logic [CW-1:0] cmd_log [0:63];
    logic [AW_A-1:0] addr_prev = '0;
    always @(negedge clk) begin
        if (ifa.start_transaction) begin
            cmd_log[pulses_a & 63] <= ifa.afe_command;
            pulses_a <= pulses_a + 1;
        end
        if (addr_prev == AW_A'(1) && ifa.rom_address == '0) jumps_a <= jumps_a + 1;
        addr_prev <= ifa.rom_address;
        if (ifb.start_transaction) pulses_b <= pulses_b + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] word(input logic [3:0] op, input logic [CW-1:0] pl);
        return {op, pl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart_pulse();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic enable_pulse_a();
        enable_a = 1'b1;
        tick();
        enable_a = 1'b0;
    endtask

    // Returns the number of clock edges after the enable edge until done rises
    task automatic wait_done_a(input int budget, output int n);
        n = 0;
        while (!done_a && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_start_a(input int budget, output int n);
        n = 0;
        while (!ifa.start_transaction && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int base;
        int jbase;

        ser_mode = 1;
        enable_a = 1'b0;
        enable_b = 1'b0;
        restart  = 1'b0;
        reset_n  = 1'b0;
        for (int i = 0; i < 256; i++) rom_a[i] = '0;
        rom_b[0] = word(4'b0011, CW'(3));
        rom_b[1] = '0;
        rom_b[2] = '0;
        rom_b[3] = word(4'b0001, CW'('h55));
        repeat (3) tick();

        // Reset values
        check("rst_addr",  32'(ifa.rom_address), 32'h0);
        check("rst_cmd",   32'(ifa.afe_command), 32'h0);
        check("rst_start", 32'(ifa.start_transaction), 32'h0);
        check("rst_done",  32'(done_a), 32'h0);
        check("rst_err",   32'(err_a), 32'h0);
        check("rst_busy",  32'(busy_a), 32'h0);
        reset_n = 1'b1;
        tick();

        // Two SENDs then DONE with the serial model
        ser_mode = 0;
        rom_a[0] = word(4'b0001, CW'('h12345));
        rom_a[1] = word(4'b0001, CW'('hABCDE));
        rom_a[2] = word(4'b0000, CW'(0));
        base = pulses_a;
        enable_pulse_a();
        wait_done_a(300, n);
        check("t1_done",   32'(done_a), 32'h1);
        check("t1_pulses", 32'(pulses_a - base), 32'd2);
        check("t1_cmd0",   32'(cmd_log[base & 63]), 32'h12345);
        check("t1_cmd1",   32'(cmd_log[(base + 1) & 63]), 32'hABCDE);
        check("t1_err",    32'(err_a), 32'h0);
        check("t1_addr",   32'(ifa.rom_address), 32'h2);
        check("t1_busy",   32'(busy_a), 32'h0);
        repeat (3) tick();
        check("t1_done_hold", 32'(done_a), 32'h1);

        // DELAY 5 then SEND: start appears 11 edges after the enable edge
        restart_pulse();
        rom_a[0] = word(4'b0010, CW'(5));
        rom_a[1] = word(4'b0001, CW'(1));
        rom_a[2] = word(4'b0000, CW'(0));
        base = pulses_a;
        enable_pulse_a();
        wait_start_a(100, n);
        check("t2_delay5_latency", 32'(n), 32'd11);
        check("t2_delay5_cmd", 32'(ifa.afe_command), 32'h1);
        wait_done_a(100, n);
        check("t2_delay5_done", 32'(done_a), 32'h1);
        check("t2_delay5_err", 32'(err_a), 32'h0);
        check("t2_delay5_pulses", 32'(pulses_a - base), 32'd1);

        // DELAY 0 skips the DELAY state entirely
        restart_pulse();
        rom_a[0] = word(4'b0010, CW'(0));
        enable_pulse_a();
        wait_start_a(100, n);
        check("t2_delay0_latency", 32'(n), 32'd6);
        wait_done_a(100, n);
        check("t2_delay0_err", 32'(err_a), 32'h0);

        // SEND / JUMP 0 loop, restart on the third start pulse
        restart_pulse();
        rom_a[0] = word(4'b0001, CW'(1));
        rom_a[1] = word(4'b0011, CW'(0));
        rom_a[2] = '0;
        base  = pulses_a;
        jbase = jumps_a;
        enable_pulse_a();
        n = 0;
        while (!(ifa.start_transaction && (pulses_a - base) == 2) && n < 300) begin
            tick();
            n++;
        end
        check("t3_third_pulse", 32'(ifa.start_transaction), 32'h1);
        check("t3_addr_at_pulse", 32'(ifa.rom_address), 32'h1);
        check("t3_jumps", 32'(jumps_a - jbase), 32'd2);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("t3_rs_busy",  32'(busy_a), 32'h0);
        check("t3_rs_done",  32'(done_a), 32'h0);
        check("t3_rs_addr",  32'(ifa.rom_address), 32'h0);
        check("t3_rs_start", 32'(ifa.start_transaction), 32'h0);
        check("t3_rs_cmd",   32'(ifa.afe_command), 32'h1);
        tick();
        check("t3_idle_hold", 32'(busy_a), 32'h0);

        // Ready held low: timeout after 16 WAIT_READY cycles
        ser_mode = 2;
        restart_pulse();
        base = pulses_a;
        enable_pulse_a();
        wait_done_a(100, n);
        check("t4_wr_latency", 32'(n), 32'd16);
        check("t4_wr_err", 32'(err_a), 32'h2);
        check("t4_wr_pulses", 32'(pulses_a - base), 32'd0);

        // Ready held high after SEND: timeout in WAIT_BUSY
        ser_mode = 1;
        rom_a[0] = word(4'b0001, CW'('h777));
        rom_a[1] = word(4'b0000, CW'(0));
        restart_pulse();
        base = pulses_a;
        enable_pulse_a();
        wait_done_a(100, n);
        check("t4_wb_latency", 32'(n), 32'd19);
        check("t4_wb_err", 32'(err_a), 32'h2);
        check("t4_wb_pulses", 32'(pulses_a - base), 32'd1);
        check("t4_wb_cmd", 32'(ifa.afe_command), 32'h777);

        // Invalid opcode 0111 at address 3
        rom_a[0] = word(4'b0011, CW'(3));
        rom_a[3] = word(4'b0111, CW'(0));
        restart_pulse();
        base = pulses_a;
        enable_pulse_a();
        wait_done_a(100, n);
        check("t5_inv_done", 32'(done_a), 32'h1);
        check("t5_inv_err", 32'(err_a), 32'h1);
        check("t5_inv_addr", 32'(ifa.rom_address), 32'h3);
        check("t5_inv_pulses", 32'(pulses_a - base), 32'd0);

        // Address overflow: SEND at the last address of a 2-bit ROM
        base = pulses_b;
        enable_b = 1'b1;
        tick();
        enable_b = 1'b0;
        n = 0;
        while (!done_b && n < 100) begin
            tick();
            n++;
        end
        check("t5_ovf_done", 32'(done_b), 32'h1);
        check("t5_ovf_err", 32'(err_b), 32'h3);
        check("t5_ovf_addr", 32'(ifb.rom_address), 32'h3);
        check("t5_ovf_pulses", 32'(pulses_b - base), 32'd0);
        check("t5_ovf_cmd", 32'(ifb.afe_command), 32'h0);

        // Reset asserted during the start pulse
        ser_mode = 0;
        rom_a[0] = word(4'b0001, CW'('h99));
        rom_a[1] = word(4'b0000, CW'(0));
        restart_pulse();
        enable_pulse_a();
        wait_start_a(100, n);
        check("t6_pulse_seen", 32'(ifa.start_transaction), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_rst_start", 32'(ifa.start_transaction), 32'h0);
        check("t6_rst_cmd",   32'(ifa.afe_command), 32'h0);
        check("t6_rst_addr",  32'(ifa.rom_address), 32'h0);
        check("t6_rst_busy",  32'(busy_a), 32'h0);
        check("t6_rst_done",  32'(done_a), 32'h0);
        reset_n = 1'b1;
        tick();

        // restart and enable together: restart wins, enable taken next cycle
        ser_mode = 1;
        enable_a = 1'b1;
        restart  = 1'b1;
        tick();
        check("t6_both_idle", 32'(busy_a), 32'h0);
        restart = 1'b0;
        tick();
        check("t6_enable_next", 32'(busy_a), 32'h1);
        enable_a = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
